// File: rtl/pe_nic_if.sv
// PE-side bundle of a mesh node: PE send/receive handshakes
// plus the router PE port (pesi/pedi/peri, peso/pedo/pero).
interface pe_nic_if;
   logic        polarity;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  tx_dst_row;
   logic [1:0]  tx_dst_col;
   logic [31:0] tx_payload;
   logic        pesi;
   logic [63:0] pedi;
   logic        peri;
   logic        pero;
   logic [63:0] pedo;
   logic        peso;
   logic        rx_valid;
   logic        rx_ready;
   logic [1:0]  rx_src_row;
   logic [1:0]  rx_src_col;
   logic [31:0] rx_payload;
   logic        err_self;
   logic        err_ovf;

   modport slave (
      input  polarity, tx_valid, tx_dst_row, tx_dst_col, tx_payload,
      input  peri, pedo, peso, rx_ready,
      output tx_ready, pesi, pedi, pero,
      output rx_valid, rx_src_row, rx_src_col, rx_payload,
      output err_self, err_ovf
   );

   modport master (
      output polarity, tx_valid, tx_dst_row, tx_dst_col, tx_payload,
      output peri, pedo, peso, rx_ready,
      input  tx_ready, pesi, pedi, pero,
      input  rx_valid, rx_src_row, rx_src_col, rx_payload,
      input  err_self, err_ovf
   );
endinterface

// File: rtl/pe_nic.sv
// Mesh network interface for one PE: packs requests into 64-bit
// packets for the router and unpacks ejected packets for the PE.
module pe_nic #(
   parameter int ROW      = 0,
   parameter int COL      = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   pe_nic_if.slave nic
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [1:0] MY_ROW = 2'(ROW);
   localparam logic [1:0] MY_COL = 2'(COL);
   localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
   localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

   logic [62:0]    tx_mem_q [TX_DEPTH];
   logic [TAW-1:0] tx_wp_q, tx_wp_d;
   logic [TAW-1:0] tx_rp_q, tx_rp_d;
   logic [TAW:0]   tx_cnt_q, tx_cnt_d;
   logic           pesi_q, pesi_d;
   logic [63:0]    pedi_q, pedi_d;
   logic           err_self_q, err_self_d;
   logic           tx_full, tx_empty;
   logic           tx_acc, tx_self, tx_push, tx_pop;
   logic           tx_ydir, tx_xdir;
   logic [1:0]     tx_dr, tx_dc;
   logic [62:0]    tx_hdr;

   logic [35:0]    rx_mem_q [RX_DEPTH];
   logic [RAW-1:0] rx_wp_q, rx_wp_d;
   logic [RAW-1:0] rx_rp_q, rx_rp_d;
   logic [RAW:0]   rx_cnt_q, rx_cnt_d;
   logic           pero_q, pero_d;
   logic           err_ovf_q, err_ovf_d;
   logic           rx_empty, rx_push, rx_pop;
   logic [35:0]    rx_head;
   logic           unused_pedo;

   assign unused_pedo = ^{nic.pedo[63:42], nic.pedo[39:34]};

   // Header is built at accept time; vc is stamped at injection.
   always_comb begin
      tx_ydir = nic.tx_dst_row > MY_ROW;
      tx_xdir = nic.tx_dst_col > MY_COL;
      tx_dr   = tx_ydir ? nic.tx_dst_row - MY_ROW
                        : MY_ROW - nic.tx_dst_row;
      tx_dc   = tx_xdir ? nic.tx_dst_col - MY_COL
                        : MY_COL - nic.tx_dst_col;
      tx_hdr  = {tx_ydir, tx_xdir, 5'd0,
                 2'd0, tx_dr, 2'd0, tx_dc,
                 6'd0, MY_ROW, 6'd0, MY_COL,
                 nic.tx_payload};
   end

   always_comb begin
      tx_full  = tx_cnt_q == TX_FULL;
      tx_empty = tx_cnt_q == '0;
      tx_acc   = nic.tx_valid && !tx_full;
      tx_self  = nic.tx_dst_row == MY_ROW &&
                 nic.tx_dst_col == MY_COL;
      tx_push  = tx_acc && !tx_self;
      tx_pop   = !tx_empty && nic.peri;
      tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
      tx_rp_d  = tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      unique case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase
      pesi_d     = tx_pop;
      pedi_d     = tx_pop ? {nic.polarity, tx_mem_q[tx_rp_q]}
                          : 64'd0;
      err_self_d = err_self_q | (tx_acc & tx_self);
   end

   always_comb begin
      rx_empty = rx_cnt_q == '0;
      rx_push  = nic.peso && pero_q;
      rx_pop   = !rx_empty && nic.rx_ready;
      rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
      rx_rp_d  = rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      unique case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase
      // pero tracks whether next-cycle occupancy leaves a free slot
      pero_d    = rx_cnt_d < RX_FULL;
      err_ovf_d = err_ovf_q | (nic.peso & ~pero_q);
      rx_head   = rx_empty ? 36'd0 : rx_mem_q[rx_rp_q];
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= tx_hdr;
      if (rx_push) rx_mem_q[rx_wp_q] <= {nic.pedo[41:40],
                                         nic.pedo[33:32],
                                         nic.pedo[31:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         tx_cnt_q   <= '0;
         pesi_q     <= 1'b0;
         pedi_q     <= 64'd0;
         err_self_q <= 1'b0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         rx_cnt_q   <= '0;
         pero_q     <= 1'b1;
         err_ovf_q  <= 1'b0;
      end else begin
         tx_wp_q    <= tx_wp_d;
         tx_rp_q    <= tx_rp_d;
         tx_cnt_q   <= tx_cnt_d;
         pesi_q     <= pesi_d;
         pedi_q     <= pedi_d;
         err_self_q <= err_self_d;
         rx_wp_q    <= rx_wp_d;
         rx_rp_q    <= rx_rp_d;
         rx_cnt_q   <= rx_cnt_d;
         pero_q     <= pero_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   assign nic.tx_ready   = !tx_full;
   assign nic.pesi       = pesi_q;
   assign nic.pedi       = pedi_q;
   assign nic.pero       = pero_q;
   assign nic.rx_valid   = !rx_empty;
   assign nic.rx_src_row = rx_head[35:34];
   assign nic.rx_src_col = rx_head[33:32];
   assign nic.rx_payload = rx_head[31:0];
   assign nic.err_self   = err_self_q;
   assign nic.err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_pe_nic.sv
// Bench for pe_nic: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random run.
module tb_pe_nic;
   localparam int ROW = 1;
   localparam int COL = 1;
   localparam int TXD = 4;
   localparam int RXD = 4;

   typedef struct {
      logic [1:0]  r;
      logic [1:0]  c;
      logic [31:0] p;
   } req_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pe_nic_if ifc ();

   pe_nic #(
      .ROW(ROW), .COL(COL), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .nic(ifc.slave)
   );

   req_t        txq[$];
   logic [63:0] rxq[$];
   bit          m_pesi, m_pero, m_es, m_eo;
   logic [63:0] m_pedi;

   int          n_pass = 0;
   int          n_tot = 0;
   bit          checks_on = 0;
   int          cyc = 0;
   logic [63:0] cap[$];
   int          cap_cyc[$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at cycle %0d",
                    name, act, exp, cyc);
   endtask

   function automatic logic [63:0] pkt(logic vc, req_t q);
      int dy, dx;
      dy = int'(q.r) - ROW;
      dx = int'(q.c) - COL;
      return {vc, dy > 0, dx > 0, 5'd0,
              4'(dy < 0 ? -dy : dy), 4'(dx < 0 ? -dx : dx),
              8'(ROW), 8'(COL), q.p};
   endfunction

   task automatic model_step();
      bit acc, self_a, rpop, rpush;
      req_t q;
      if (reset) begin
         txq.delete();
         rxq.delete();
         m_pesi = 0;
         m_pedi = 64'd0;
         m_pero = 1;
         m_es = 0;
         m_eo = 0;
         return;
      end
      acc = ifc.tx_valid && txq.size() < TXD;
      self_a = ifc.tx_dst_row == ROW && ifc.tx_dst_col == COL;
      if (txq.size() > 0 && ifc.peri) begin
         m_pesi = 1;
         m_pedi = pkt(ifc.polarity, txq.pop_front());
      end else begin
         m_pesi = 0;
         m_pedi = 64'd0;
      end
      if (acc) begin
         if (self_a) m_es = 1;
         else begin
            q.r = ifc.tx_dst_row;
            q.c = ifc.tx_dst_col;
            q.p = ifc.tx_payload;
            txq.push_back(q);
         end
      end
      rpop = rxq.size() > 0 && ifc.rx_ready;
      rpush = ifc.peso && m_pero;
      if (ifc.peso && !m_pero) m_eo = 1;
      if (rpop) void'(rxq.pop_front());
      if (rpush) rxq.push_back(ifc.pedo);
      m_pero = rxq.size() < RXD;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      ifc.polarity = ~ifc.polarity;
   end

   // Per-cycle comparison of every output against the model.
   initial forever begin
      logic [63:0] h;
      @(negedge clk);
      cyc++;
      if (checks_on) begin
         h = rxq.size() > 0 ? rxq[0] : 64'd0;
         chk("tx_ready", ifc.tx_ready, txq.size() < TXD);
         chk("pesi", ifc.pesi, m_pesi);
         chk("pedi", ifc.pedi, m_pedi);
         chk("pero", ifc.pero, m_pero);
         chk("rx_valid", ifc.rx_valid, rxq.size() > 0);
         chk("rx_src_row", ifc.rx_src_row, h[41:40]);
         chk("rx_src_col", ifc.rx_src_col, h[33:32]);
         chk("rx_payload", ifc.rx_payload, h[31:0]);
         chk("err_self", ifc.err_self, m_es);
         chk("err_ovf", ifc.err_ovf, m_eo);
         if (ifc.pesi) begin
            cap.push_back(ifc.pedi);
            cap_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(logic [1:0] r, logic [1:0] c, logic [31:0] p);
      @(negedge clk);
      ifc.tx_valid = 1'b1;
      ifc.tx_dst_row = r;
      ifc.tx_dst_col = c;
      ifc.tx_payload = p;
   endtask

   task automatic idle(int n);
      @(negedge clk);
      ifc.tx_valid = 1'b0;
      ifc.peso = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   logic [14:0] exp15 [4];
   logic [1:0]  dr [4];
   logic [1:0]  dc [4];

   initial begin
      exp15 = '{15'h0011, 15'h2011, 15'h4011, 15'h6022};
      dr = '{2'd0, 2'd0, 2'd2, 2'd3};
      dc = '{2'd0, 2'd2, 2'd0, 2'd3};
      ifc.polarity = 1'b0;
      ifc.tx_valid = 1'b0;
      ifc.tx_dst_row = 2'd0;
      ifc.tx_dst_col = 2'd0;
      ifc.tx_payload = 32'd0;
      ifc.peri = 1'b0;
      ifc.pedo = 64'd0;
      ifc.peso = 1'b0;
      ifc.rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks_on = 1;
      #1;
      chk("reset_tx_ready", ifc.tx_ready, 1);
      chk("reset_pero", ifc.pero, 1);
      chk("reset_rx_valid", ifc.rx_valid, 0);

      // Four destinations around (1,1), injected back to back
      ifc.peri = 1'b1;
      cap.delete();
      cap_cyc.delete();
      for (int i = 0; i < 4; i++) send(dr[i], dc[i], 32'hA000_0000 + i);
      idle(5);
      chk("t1_count", cap.size(), 4);
      for (int i = 0; i < 4 && i < cap.size(); i++) begin
         chk("t1_hdr", cap[i][62:48], exp15[i]);
         chk("t1_src", cap[i][47:32], 16'h0101);
         chk("t1_pay", cap[i][31:0], 32'hA000_0000 + i);
         chk("t1_b2b", cap_cyc[i], cap_cyc[0] + i);
      end

      // Fill TX with router stalled, then release
      ifc.peri = 1'b0;
      for (int i = 0; i < 5; i++) send(2'd3, 2'd3, 32'(i));
      idle(1);
      chk("t2_full", ifc.tx_ready, 0);
      cap.delete();
      cap_cyc.delete();
      ifc.peri = 1'b1;
      idle(6);
      chk("t2_count", cap.size(), 4);
      for (int i = 0; i < 4 && i < cap.size(); i++) begin
         chk("t2_pay", cap[i][31:0], 32'(i));
         chk("t2_b2b", cap_cyc[i], cap_cyc[0] + i);
      end
      chk("t2_ready", ifc.tx_ready, 1);

      // Self-addressed request
      cap.delete();
      send(2'd1, 2'd1, 32'h5E1F);
      idle(3);
      chk("t3_nopesi", cap.size(), 0);
      chk("t3_err_self", ifc.err_self, 1);

      // RX fill, overflow, drain
      ifc.rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ifc.peso = 1'b1;
         ifc.pedo = {16'h0, 8'h02, 8'h03, 32'hBBBB_BBB0 + 32'(i)};
      end
      idle(1);
      chk("t4_pero", ifc.pero, 0);
      chk("t4_err_ovf", ifc.err_ovf, 1);
      ifc.rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_valid", ifc.rx_valid, 1);
         chk("t4_row", ifc.rx_src_row, 2);
         chk("t4_col", ifc.rx_src_col, 3);
         chk("t4_pay", ifc.rx_payload, 32'hBBBB_BBB0 + 32'(i));
         @(negedge clk);
         #1;
      end
      chk("t4_empty", ifc.rx_valid, 0);
      ifc.rx_ready = 1'b0;

      // Push and pop together at count 3
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ifc.peso = 1'b1;
         ifc.pedo = {32'h0001_0200, 32'(i)};
      end
      @(negedge clk);
      ifc.pedo = {32'h0001_0200, 32'd3};
      ifc.rx_ready = 1'b1;
      @(negedge clk);
      ifc.peso = 1'b0;
      ifc.rx_ready = 1'b0;
      #1;
      chk("t5_pero", ifc.pero, 1);
      chk("t5_head", ifc.rx_payload, 32'd1);
      ifc.rx_ready = 1'b1;
      idle(4);
      ifc.rx_ready = 1'b0;

      // Reset with both FIFOs half full
      ifc.peri = 1'b0;
      send(2'd0, 2'd0, 32'h11);
      send(2'd0, 2'd3, 32'h22);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ifc.tx_valid = 1'b0;
         ifc.peso = 1'b1;
         ifc.pedo = {$urandom(), $urandom()};
      end
      @(negedge clk);
      ifc.peso = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_pesi", ifc.pesi, 0);
      chk("t6_pedi", ifc.pedi, 0);
      chk("t6_rx_valid", ifc.rx_valid, 0);
      chk("t6_tx_ready", ifc.tx_ready, 1);
      chk("t6_pero", ifc.pero, 1);
      chk("t6_err_self", ifc.err_self, 0);
      chk("t6_err_ovf", ifc.err_ovf, 0);
      ifc.peri = 1'b1;

      // Random traffic with varying back-pressure
      for (int i = 0; i < 3000; i++) begin
         int ph;
         ph = (i / 300) % 3;
         @(negedge clk);
         reset = ($urandom_range(0, 599) == 0);
         ifc.tx_valid = $urandom_range(0, 1) == 1;
         ifc.tx_dst_row = 2'($urandom_range(0, 3));
         ifc.tx_dst_col = 2'($urandom_range(0, 3));
         ifc.tx_payload = $urandom();
         ifc.peri = ph == 0 ? 1'b1 : ($urandom_range(0, 3) == 0);
         ifc.peso = $urandom_range(0, 2) != 0;
         ifc.pedo = {$urandom(), $urandom()};
         ifc.rx_ready = ph == 2 ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      idle(6);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/pe_nic.md
Name: pe_nic

Overview:
- Processing-element network interface for one mesh4x4 node; sits between a PE and the PE port of its router.
- TX path: takes (dest row, dest col, payload) requests, builds 64-bit mesh packets, and injects them via pesi/pedi/peri.
- RX path: ejects packets from peso/pedo/pero, buffers them, and unpacks source and payload for the PE.
- Is the PE-side end of the interface that routers expose as pesi/pedi/peri/pero/pedo/peso.

Parameters:
ROW, 0, this node's row (0..3)
COL, 0, this node's column (0..3)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
polarity  in  1  mesh polarity; toggles every cycle
tx_valid  in  1  PE send request
tx_ready  out  1  TX FIFO not full
tx_dst_row  in  2  destination row
tx_dst_col  in  2  destination column
tx_payload  in  32  payload
pesi  out  1  packet valid into router
pedi  out  64  packet into router
peri  in  1  router PE input buffer can accept
pero  out  1  NIC can accept ejected packet
pedo  in  64  packet from router
peso  in  1  ejected packet valid
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  PE pops RX head
rx_src_row  out  2  RX head source row
rx_src_col  out  2  RX head source column
rx_payload  out  32  RX head payload
err_self  out  1  sticky; self-addressed request dropped
err_ovf  out  1  sticky; peso seen while pero=0, packet dropped

Behaviour:
- Single clock domain. Reset is synchronous and active-high. On reset, all outputs are 0 except tx_ready=1 and pero=1, both FIFOs are emptied, and both sticky flags are cleared. Reset mid-transfer discards all buffered packets.
- Packet format: [63] vc, [62] ydir (1=toward higher row), [61] xdir (1=toward higher col), [60:56] 0, [55:52] |dst_row-ROW|, [51:48] |dst_col-COL|, [47:40] source row zero-extended, [39:32] source col zero-extended, [31:0] payload.
- Example: ROW=1,COL=1, dst (0,2) gives bits[62:48] = {2'b01,5'b0,8'h11}.
- TX accept: a request is accepted at an edge where tx_valid && tx_ready. The header is computed at accept time and the entry pushed with vc unset.
- Self-address: a request with dst == (ROW,COL) is accepted (tx_ready honoured) but not pushed, and err_self is set.
- tx_ready is !full, combinational from FIFO occupancy.
- TX inject:
  - Each edge, if the TX FIFO is non-empty and peri==1: pesi<=1, pedi<=head with [63]=polarity sampled at that edge, and the FIFO pops. Otherwise pesi<=0 and pedi<=0.
  - At most one packet per cycle. Back-to-back injection is allowed while peri stays 1.
  - Latency: accept at edge N gives pesi=1 after edge N+1 at the earliest.
  - Push and pop may occur on the same edge, including when the FIFO is full, where tx_ready=0 so no push happens.
- RX eject:
  - pero is registered: pero<=(RX count < RX_DEPTH-1) || (count==RX_DEPTH-1 && no push this edge) || pop this edge. Equivalently, pero is 1 whenever next-cycle occupancy < RX_DEPTH.
  - At an edge with peso && pero, pedo is pushed.
  - At an edge with peso && !pero, the packet is dropped and err_ovf is set.
- RX output: rx_valid = !empty. rx_src_row/col = head[41:40]/[33:32]. rx_payload = head[31:0]. These are combinational from the head and are 0 when empty.
- A pop occurs at an edge where rx_valid && rx_ready. Simultaneous push and pop keeps the count unchanged.
- FIFO pointers wrap modulo depth. Count width is log2(depth)+1.
- Both sticky errors clear only on reset.

Test Plan:
- ROW=1,COL=1, peri=1, send to (0,0),(0,2),(2,0),(3,3) on consecutive cycles -> four consecutive pesi pulses. pedi[62:48] = {00,0,8'h11},{01,0,8'h11},{10,0,8'h11},{11,0,8'h22}. Source 16'h0101 in each. [63] equals polarity at each injecting edge.
- peri=0, issue 5 requests with TX_DEPTH=4 -> tx_ready drops after 4 accepts. Raise peri -> exactly 4 packets emitted in order, pesi back-to-back, then tx_ready=1.
- Send to (1,1) -> no pesi, err_self=1 and stays set until reset.
- Drive peso with 4 packets, source 16'h0203 and payload 32'hBBBB_BBBB..., rx_ready=0 -> pero deasserts after the 4th push. A 5th peso sets err_ovf. Pop all with rx_ready=1 -> rx_src_row=2, rx_src_col=3, payloads in order.
- Simultaneous RX push and pop at count 3 -> count stays 3 and pero stays 1. TX push and pop on the same edge -> occupancy unchanged.
- Assert reset with both FIFOs half full -> the next cycle shows pesi=0, pedi=0, rx_valid=0, tx_ready=1, pero=1, and errors cleared.
